regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two writers share one write port, with
// starvation-bounded fixed priority and a busy-bit scoreboard for hazard lookup.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid0,
    input  logic [4:0]  addr0,
    input  logic [31:0] data0,
    output logic        ready0,
    input  logic        valid1,
    input  logic [4:0]  addr1,
    input  logic [31:0] data1,
    output logic        ready1,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] busy_q, busy_d;

    logic starve;
    logic grant0;
    logic grant1;

    always_comb begin
        starve = (starve_cnt_q == LIMIT);
        ready0 = !starve;
        ready1 = starve || !valid0;
        grant0 = valid0 && ready0;
        grant1 = valid1 && ready1;
    end

    // Refusal counter: any cycle requester 1 is idle or served restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!valid1 || grant1) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (grant0) begin
            wb_we_d   = (addr0 != 5'd0);
            wb_addr_d = addr0;
            wb_data_d = data0;
        end else if (grant1) begin
            wb_we_d   = (addr1 != 5'd0);
            wb_addr_d = addr1;
            wb_data_d = data1;
        end
    end

    // Clear before set so a same-cycle issue to the retiring register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (grant1) begin
            busy_d[addr1] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            wb_we_q      <= 1'b0;
            wb_addr_q    <= 5'd0;
            wb_data_q    <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_we_q      <= wb_we_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        wb_we    = wb_we_q;
        wb_addr  = wb_addr_q;
        wb_data  = wb_data_q;
        rs1_busy = busy_q[query_rs1];
        rs2_busy = busy_q[query_rs2];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid0, valid1, issue_valid;
    logic [4:0]  addr0, addr1, issue_rd, query_rs1, query_rs2;
    logic [31:0] data0, data1;
    logic        ready0, ready1, rs1_busy, rs2_busy, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_busy [32];
    int          m_refused;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
        .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_refused = 0;
        m_we      = 1'b0;
        m_addr    = 5'd0;
        m_data    = 32'd0;
    endtask

    task automatic idle_inputs();
        valid0 = 0; addr0 = 0; data0 = 0;
        valid1 = 0; addr1 = 0; data1 = 0;
        issue_valid = 0; issue_rd = 0;
        query_rs1 = 0; query_rs2 = 0;
    endtask

    // One clock cycle: check combinational outputs against the model, advance
    // the model across the edge, then check the registered writeback outputs.
    task automatic tick();
        bit starve, r0, r1, g0, g1;
        #1;
        starve = (m_refused == STARVE_LIMIT);
        r0 = !starve;
        r1 = starve || !valid0;
        check("ready0", ready0, r0);
        check("ready1", ready1, r1);
        check("rs1_busy", rs1_busy, m_busy[query_rs1]);
        check("rs2_busy", rs2_busy, m_busy[query_rs2]);
        g0 = valid0 && r0;
        g1 = valid1 && r1;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (g0) begin
                m_we = (addr0 != 0); m_addr = addr0; m_data = data0;
            end else if (g1) begin
                m_we = (addr1 != 0); m_addr = addr1; m_data = data1;
            end else begin
                m_we = 1'b0;
            end
            if (g1) m_busy[addr1] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (valid1 && !g1) m_refused = (m_refused + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_refused + 1;
            else m_refused = 0;
        end
        #1;
        check("wb_we", wb_we, m_we);
        check("wb_addr", wb_addr, m_addr);
        check("wb_data", wb_data, m_data);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #1;
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_ready0", ready0, 1);
        valid0 = 1;
        #1;
        check("rst_ready1", ready1, 0);
        valid0 = 0;
        @(posedge clock); #1;
        reset = 1'b0;

        // Single writer on requester 0
        valid0 = 1; addr0 = 5; data0 = 32'hDEADBEEF;
        #1 check("d27_ready0", ready0, 1);
        tick();
        check("d27_we", wb_we, 1);
        check("d27_addr", wb_addr, 5);
        check("d27_data", wb_data, 32'hDEADBEEF);
        idle_inputs();
        tick();
        check("idle_we", wb_we, 0);
        check("idle_hold", wb_data, 32'hDEADBEEF);

        // Starvation: requester 1 refused STARVE_LIMIT cycles, then forced through
        valid0 = 1; addr0 = 2; data0 = 32'h1111_0000;
        valid1 = 1; addr1 = 3; data1 = 32'h2222_0000;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #1 check("starve_r1_low", ready1, 0);
            tick();
        end
        #1;
        check("starve_r0_low", ready0, 0);
        check("starve_r1_high", ready1, 1);
        tick();
        check("starve_wb_addr", wb_addr, 3);
        check("starve_wb_data", wb_data, 32'h2222_0000);
        check("starve_cleared", ready1, 0);
        idle_inputs();
        tick();

        // Scoreboard set, lookup, clear on grant1
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0; query_rs1 = 7;
        #1 check("sb_set", rs1_busy, 1);
        valid1 = 1; addr1 = 7; data1 = 32'hCAFE0007;
        tick();
        check("sb_clear", rs1_busy, 0);
        valid1 = 0;

        // Same-cycle set and clear: set wins
        issue_valid = 1; issue_rd = 9;
        valid1 = 1; addr1 = 9; data1 = 32'h9;
        tick();
        idle_inputs();
        query_rs2 = 9;
        #1 check("sb_set_wins", rs2_busy, 1);
        tick();

        // Address 0: consumed but not written, and never busy
        valid0 = 1; addr0 = 0; data0 = 32'h0BAD0000;
        #1 check("a0_ready0", ready0, 1);
        tick();
        check("a0_we", wb_we, 0);
        idle_inputs();
        issue_valid = 1; issue_rd = 0;
        tick();
        issue_valid = 0; query_rs1 = 0;
        #1 check("a0_not_busy", rs1_busy, 0);

        // Asynchronous reset mid-cycle with busy[3] set and a grant pending
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_valid = 0; query_rs1 = 3;
        valid0 = 1; addr0 = 10; data0 = 32'h0A0A0A0A;
        tick();
        valid0 = 1; addr0 = 12; data0 = 32'h0C0C0C0C;
        #2;
        check("pre_rst_busy", rs1_busy, 1);
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_we", wb_we, 0);
        check("arst_busy", rs1_busy, 0);
        tick();
        check("arst_no_write", wb_we, 0);
        reset = 1'b0;
        valid0 = 1; addr0 = 14; data0 = 32'h0E0E0E0E;
        tick();
        check("post_rst_first", wb_we, 1);
        idle_inputs();

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            valid0      = ($urandom_range(0, 99) < 55);
            valid1      = ($urandom_range(0, 99) < 60);
            addr0       = 5'($urandom_range(0, 7));
            addr1       = 5'($urandom_range(0, 7));
            data0       = $urandom;
            data1       = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rd    = 5'($urandom_range(0, 7));
            query_rs1   = 5'($urandom_range(0, 7));
            query_rs2   = 5'($urandom_range(0, 31));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
